// File: rtl/mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mmio_pkg
// Brief    : Address map and FSM encoding shared by the MMIO responder.
// Revision : 1.0 - initial release
// ============================================================================
package mmio_pkg;

    localparam logic [31:0] IO_LED_ADDR    = 32'hFFFF_FC04;
    localparam logic [31:0] IO_SEG_ADDR    = 32'hFFFF_FC08;
    localparam logic [31:0] IO_SW_ADDR     = 32'hFFFF_FC10;
    localparam logic [31:0] IO_SW_BLK_ADDR = 32'hFFFF_FC14;
    localparam logic [31:0] IO_STATUS_ADDR = 32'hFFFF_FC18;

    localparam logic [1:0] C_ST_IDLE       = 2'd0;
    localparam logic [1:0] C_ST_RESP       = 2'd1;
    localparam logic [1:0] C_ST_WAIT_PRESS = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE       = C_ST_IDLE,
        ST_RESP       = C_ST_RESP,
        ST_WAIT_PRESS = C_ST_WAIT_PRESS
    } mmio_state_e;

endpackage : mmio_pkg
`default_nettype wire

// File: rtl/btn_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : btn_debouncer
// Brief    : 2-FF synchronizer, stability counter and press pulse for a button.
// Revision : 1.0 - initial release
// ============================================================================
module btn_debouncer #(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic stable,
    output logic press_evt
);

    logic        r_sync1;
    logic        r_sync2;
    logic [19:0] r_cnt;
    logic        r_stable;
    logic        r_press;

    // The counter only runs while the synced level disagrees with the accepted
    // level; any return to agreement (a bounce) restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_cnt    <= 20'd0;
            r_stable <= 1'b0;
            r_press  <= 1'b0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_stable) begin
                r_cnt <= 20'd0;
            end else if (r_cnt == DEBOUNCE_CYCLES - 20'd1) begin
                r_stable <= r_sync2;
                r_cnt    <= 20'd0;
                r_press  <= r_sync2;
            end else begin
                r_cnt <= r_cnt + 20'd1;
            end
        end
    end

    assign stable    = r_stable;
    assign press_evt = r_press;

endmodule : btn_debouncer
`default_nettype wire

// File: rtl/mmio_responder.sv
`default_nettype none
// ============================================================================
// Module   : mmio_responder
// Brief    : IO-port responder for LEDs, 7-seg, switches and confirm button.
// Revision : 1.0 - initial release
// ============================================================================
module mmio_responder
    import mmio_pkg::*;
#(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd100000,
    parameter int          SW_W            = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            io_read,
    input  logic            io_write,
    input  logic [31:0]     addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic            rdata_valid,
    output logic            stall,
    input  logic [SW_W-1:0] switches,
    input  logic            btn_confirm,
    output logic [SW_W-1:0] leds,
    output logic [31:0]     seg_value
);

    mmio_state_e     r_state;
    logic [SW_W-1:0] r_sw_sync1;
    logic [SW_W-1:0] r_sw_sync2;
    logic [SW_W-1:0] r_leds;
    logic [31:0]     r_seg;
    logic [31:0]     r_rdata;

    logic            w_btn_stable;
    logic            w_press_evt;
    logic            w_rd;
    logic            w_wr;
    logic            w_rd_blk;
    logic [31:0]     w_rd_mux;
    logic [31:0]     w_sw_ext;

    btn_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debouncer (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (btn_confirm),
        .stable    (w_btn_stable),
        .press_evt (w_press_evt)
    );

    // Simultaneous strobes are treated as no access at all.
    assign w_rd     = io_read & ~io_write;
    assign w_wr     = io_write & ~io_read;
    assign w_rd_blk = w_rd && (addr == IO_SW_BLK_ADDR);
    assign w_sw_ext = {{(32-SW_W){1'b0}}, r_sw_sync2};

    always_comb begin
        w_rd_mux = 32'd0;
        case (addr)
            IO_LED_ADDR:    w_rd_mux = {{(32-SW_W){1'b0}}, r_leds};
            IO_SEG_ADDR:    w_rd_mux = r_seg;
            IO_SW_ADDR:     w_rd_mux = w_sw_ext;
            IO_STATUS_ADDR: w_rd_mux = {31'd0, w_btn_stable};
            default:        w_rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw_sync1 <= '0;
            r_sw_sync2 <= '0;
        end else begin
            r_sw_sync1 <= switches;
            r_sw_sync2 <= r_sw_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_leds  <= '0;
            r_seg   <= 32'd0;
            r_rdata <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_wr) begin
                        if (addr == IO_LED_ADDR) r_leds <= wdata[SW_W-1:0];
                        if (addr == IO_SEG_ADDR) r_seg  <= wdata;
                    end else if (w_rd_blk) begin
                        r_state <= ST_WAIT_PRESS;
                    end else if (w_rd) begin
                        r_rdata <= w_rd_mux;
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                ST_WAIT_PRESS: begin
                    if (w_press_evt) begin
                        r_rdata <= w_sw_ext;
                        r_state <= ST_RESP;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // The core keeps io_read asserted while stalled, so the same-cycle stall
    // term is gated by reset to let stall fall as soon as rst_n goes low.
    assign stall       = rst_n & ((r_state == ST_WAIT_PRESS) ||
                                  ((r_state == ST_IDLE) && w_rd_blk));
    assign rdata_valid = (r_state == ST_RESP);
    assign rdata       = r_rdata;
    assign leds        = r_leds;
    assign seg_value   = r_seg;

endmodule : mmio_responder
`default_nettype wire

// File: tb/tb_mmio_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_responder
// Brief    : Self-checking bench for mmio_responder with a register-map model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_responder;

    localparam int          SW_W = 16;
    localparam logic [19:0] DEB  = 20'd4;

    localparam logic [31:0] A_LED  = 32'hFFFF_FC04;
    localparam logic [31:0] A_SEG  = 32'hFFFF_FC08;
    localparam logic [31:0] A_SW   = 32'hFFFF_FC10;
    localparam logic [31:0] A_BLK  = 32'hFFFF_FC14;
    localparam logic [31:0] A_STAT = 32'hFFFF_FC18;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            io_read;
    logic            io_write;
    logic [31:0]     addr;
    logic [31:0]     wdata;
    logic [31:0]     rdata;
    logic            rdata_valid;
    logic            stall;
    logic [SW_W-1:0] switches;
    logic            btn_confirm;
    logic [SW_W-1:0] leds;
    logic [31:0]     seg_value;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state of the register map
    logic [SW_W-1:0] m_leds = '0;
    logic [31:0]     m_seg  = 32'd0;
    logic            m_btn  = 1'b0;

    logic [31:0] addr_pool [6] = '{32'hFFFF_FC04, 32'hFFFF_FC08, 32'hFFFF_FC10,
                                   32'hFFFF_FC18, 32'hFFFF_FC20, 32'hFFFF_FC0C};

    mmio_responder #(
        .DEBOUNCE_CYCLES (DEB),
        .SW_W            (SW_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .io_read     (io_read),
        .io_write    (io_write),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .stall       (stall),
        .switches    (switches),
        .btn_confirm (btn_confirm),
        .leds        (leds),
        .seg_value   (seg_value)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        case (a)
            A_LED:   return {16'd0, m_leds};
            A_SEG:   return m_seg;
            A_SW:    return {16'd0, switches};
            A_STAT:  return {31'd0, m_btn};
            default: return 32'd0;
        endcase
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        io_read = 1'b0; io_write = 1'b1; addr = a; wdata = d;
        if (a == A_LED) m_leds = d[15:0];
        if (a == A_SEG) m_seg  = d;
        @(posedge clk); #1;
        chk("wr_leds", {16'd0, leds}, {16'd0, m_leds});
        chk("wr_seg", seg_value, m_seg);
        chk("wr_no_valid", {31'd0, rdata_valid}, 32'd0);
        @(negedge clk);
        io_write = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a);
        logic [31:0] exp;
        @(negedge clk);
        io_write = 1'b0; io_read = 1'b1; addr = a;
        exp = ref_read(a);
        #1 chk("rd_no_stall", {31'd0, stall}, 32'd0);
        chk("rd_valid_early", {31'd0, rdata_valid}, 32'd0);
        @(posedge clk); #1;
        chk("rd_valid", {31'd0, rdata_valid}, 32'd1);
        chk("rd_data", rdata, exp);
        chk("rd_resp_no_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        io_read = 1'b0;
        @(posedge clk); #1;
        chk("rd_valid_1cyc", {31'd0, rdata_valid}, 32'd0);
        chk("rd_data_hold", rdata, exp);
    endtask

    task automatic blk_start(input logic [15:0] sw);
        @(negedge clk);
        switches = sw;
        idle(3);
        @(negedge clk);
        io_write = 1'b0; io_read = 1'b1; addr = A_BLK;
        #1 chk("blk_stall_same_cycle", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        chk("blk_stall_wait", {31'd0, stall}, 32'd1);
        chk("blk_no_valid", {31'd0, rdata_valid}, 32'd0);
    endtask

    task automatic wait_drop(output int cyc);
        cyc = 0;
        while (stall && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("blk_release", {31'd0, stall}, 32'd0);
    endtask

    task automatic count_low(input int n, inout int lows);
        repeat (n) begin
            @(posedge clk); #1;
            if (!stall) lows++;
        end
    endtask

    initial begin
        int cyc;
        int lows;
        logic [31:0] a, d;

        rst_n = 1'b0; io_read = 1'b0; io_write = 1'b0;
        addr = 32'd0; wdata = 32'd0; switches = '0; btn_confirm = 1'b0;
        idle(3);
        #1;
        chk("rst_leds", {16'd0, leds}, 32'd0);
        chk("rst_seg", seg_value, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_valid", {31'd0, rdata_valid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        idle(2);

        // Directed write / read-back
        do_write(A_LED, 32'h1234_ABCD);
        chk("led_abcd", {16'd0, leds}, 32'h0000_ABCD);
        do_read(A_LED);
        chk("led_readback", rdata, 32'h0000_ABCD);

        @(negedge clk) switches = 16'h00F0;
        idle(3);
        do_read(A_SW);
        chk("sw_read", rdata, 32'h0000_00F0);

        // Randomized register traffic against the model
        for (int i = 0; i < 40; i++) begin
            @(negedge clk) switches = 16'($urandom);
            idle(3);
            a = addr_pool[$urandom_range(0, 5)];
            d = $urandom;
            if ($urandom_range(0, 1) == 0) do_write(a, d);
            else                           do_read(a);
        end

        // Illegal accesses
        do_write(A_SEG, 32'hCAFE_0001);
        @(negedge clk);
        io_read = 1'b1; io_write = 1'b1; addr = A_SEG; wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        chk("both_seg_unchanged", seg_value, 32'hCAFE_0001);
        chk("both_no_valid", {31'd0, rdata_valid}, 32'd0);
        @(posedge clk); #1;
        chk("both_no_valid2", {31'd0, rdata_valid}, 32'd0);
        @(negedge clk) begin io_read = 1'b0; io_write = 1'b0; end
        do_write(A_SW, 32'h0000_FFFF);
        do_write(A_STAT, 32'hFFFF_FFFF);
        do_read(32'hFFFF_FC20);
        chk("unmapped_zero", rdata, 32'd0);
        do_read(32'hFFFF_FC05);
        chk("misaligned_zero", rdata, 32'd0);

        // Blocking read with a bouncing button
        blk_start(16'h0055);
        lows = 0;
        @(negedge clk) btn_confirm = 1'b1;
        count_low(1, lows);
        @(negedge clk) btn_confirm = 1'b0;
        count_low(1, lows);
        @(negedge clk) btn_confirm = 1'b1;
        chk("bounce_hold", lows, 0);
        wait_drop(cyc);
        chk("blk_min_latency", {31'd0, cyc >= int'(DEB) + 2}, 32'd1);
        chk("blk_max_latency", {31'd0, cyc <= int'(DEB) + 4}, 32'd1);
        chk("blk_rdata", rdata, 32'h0000_0055);
        chk("blk_valid", {31'd0, rdata_valid}, 32'd1);
        @(negedge clk) begin io_read = 1'b0; btn_confirm = 1'b0; end
        @(posedge clk); #1;
        chk("blk_valid_1cyc", {31'd0, rdata_valid}, 32'd0);
        idle(12);

        // Button already held when the blocking read starts
        @(negedge clk) btn_confirm = 1'b1;
        idle(12);
        m_btn = 1'b1;
        do_read(A_STAT);
        blk_start(16'h00AA);
        lows = 0;
        count_low(15, lows);
        @(negedge clk) btn_confirm = 1'b0;
        count_low(12, lows);
        chk("held_no_release", lows, 0);
        m_btn = 1'b0;
        @(negedge clk) btn_confirm = 1'b1;
        wait_drop(cyc);
        chk("held_rdata", rdata, 32'h0000_00AA);
        chk("held_valid", {31'd0, rdata_valid}, 32'd1);
        @(negedge clk) begin io_read = 1'b0; btn_confirm = 1'b0; end
        idle(12);

        // Reset while waiting for the press
        do_write(A_LED, 32'h0000_5A5A);
        do_write(A_SEG, 32'h1357_9BDF);
        blk_start(16'h0033);
        idle(2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rstw_stall", {31'd0, stall}, 32'd0);
        chk("rstw_valid", {31'd0, rdata_valid}, 32'd0);
        chk("rstw_leds", {16'd0, leds}, 32'd0);
        chk("rstw_seg", seg_value, 32'd0);
        m_leds = '0;
        m_seg  = 32'd0;
        @(negedge clk) begin io_read = 1'b0; rst_n = 1'b1; end
        idle(1);
        do_read(A_LED);
        do_read(A_SEG);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mmio_responder
`default_nettype wire
